// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel frame scheduler.
package sobel_pkg;

  localparam int          ADDR_W_DEF   = 20;
  localparam int unsigned RES_BASE_DEF = 32'h0008_0000;
  localparam int          WIN_PIX      = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    WAIT_RES,
    DONE
  } state_t;

endpackage

// File: rtl/sobel_frame_sched_if.sv
// Loader stream, buffer port, window stream and result strobe of the scheduler.
interface sobel_frame_sched_if
  import sobel_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              win_valid;
  logic [7:0]        win_pix;
  logic [3:0]        win_idx;
  logic              win_last;
  logic              res_valid;
  logic [7:0]        res_data;

  modport master (
    input  ld_valid, ld_data, mem_rdata, res_valid, res_data,
    output ld_ready, mem_addr, mem_we, mem_wdata,
           win_valid, win_pix, win_idx, win_last
  );

  modport slave (
    output ld_valid, ld_data, mem_rdata, res_valid, res_data,
    input  ld_ready, mem_addr, mem_we, mem_wdata,
           win_valid, win_pix, win_idx, win_last
  );

endinterface

// File: rtl/sobel_win_addr.sv
// 3x3 window address walker: row bases are built by repeated addition of the width.
module sobel_win_addr
  import sobel_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              init,
  input  logic              step,
  input  logic [15:0]       w,
  input  logic [15:0]       h,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        idx,
  output logic              last,
  output logic [15:0]       win_x,
  output logic [15:0]       win_y
);

  logic [1:0]        c_q, c_d, r_q, r_d;
  logic [3:0]        idx_q, idx_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] win_base_q, win_base_d, row_base_q, row_base_d;
  logic [ADDR_W-1:0] w_ext;
  logic              x_end;

  assign w_ext = ADDR_W'(w);
  assign x_end = (x_q == w - 16'd3);
  assign addr  = row_base_q + ADDR_W'(x_q) + ADDR_W'(c_q);
  assign idx   = idx_q;
  assign win_x = x_q;
  assign win_y = y_q;
  assign last  = x_end && (y_q == h - 16'd3) && (idx_q == 4'(WIN_PIX - 1));

  // Advance column, then row, then window position; row base tracks (win_y + r) * w.
  always_comb begin
    // NOTE: every _d starts from its _q so no branch leaves a value unassigned (no latch).
    c_d        = c_q;
    r_d        = r_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    win_base_d = win_base_q;
    row_base_d = row_base_q;
    if (init) begin
      c_d        = '0;
      r_d        = '0;
      idx_d      = '0;
      x_d        = '0;
      y_d        = '0;
      win_base_d = '0;
      row_base_d = '0;
    end else if (step) begin
      idx_d = (idx_q == 4'(WIN_PIX - 1)) ? 4'd0 : idx_q + 4'd1;
      if (c_q != 2'd2) begin
        c_d = c_q + 2'd1;
      end else begin
        c_d = 2'd0;
        if (r_q != 2'd2) begin
          r_d        = r_q + 2'd1;
          row_base_d = row_base_q + w_ext;
        end else begin
          r_d = 2'd0;
          if (!x_end) begin
            x_d        = x_q + 16'd1;
            row_base_d = win_base_q;
          end else begin
            x_d        = 16'd0;
            y_d        = y_q + 16'd1;
            win_base_d = win_base_q + w_ext;
            row_base_d = win_base_q + w_ext;
          end
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rstn) begin
      c_q        <= '0;
      r_q        <= '0;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      win_base_q <= '0;
      row_base_q <= '0;
    end else begin
      c_q        <= c_d;
      r_q        <= r_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      win_base_q <= win_base_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/sobel_frame_sched.sv
// Frame scheduler: loads a frame, streams 3x3 windows, writes Sobel results back.
module sobel_frame_sched
  import sobel_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RES_BASE = ADDR_W'(RES_BASE_DEF)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [15:0]         W,
  input  logic [15:0]         H,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ovf,
  output logic [15:0]         win_x,
  output logic [15:0]         win_y,
  sobel_frame_sched_if.master bus
);

  state_t            state_q, state_d;
  logic [15:0]       w_q, w_d, h_q, h_d;
  logic [31:0]       npix_q, npix_d, nres_q, nres_d;
  logic [31:0]       ld_cnt_q, ld_cnt_d, res_cnt_q, res_cnt_d;
  logic              hold_full_q, hold_full_d, hold_drain_q, hold_drain_d;
  logic [7:0]        hold_data_q, hold_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              rd_q, rd_d;
  logic [3:0]        rd_idx_q, rd_idx_d;
  logic              win_valid_q, win_valid_d, win_last_q, win_last_d;
  logic [3:0]        win_idx_q, win_idx_d;
  logic              ld_ready_q, ld_ready_d, busy_q, busy_d, done_q, done_d;
  logic              err_q, err_d, ovf_q, ovf_d;

  logic              wa_init, wa_step, wa_last;
  logic [ADDR_W-1:0] wa_addr;
  logic [3:0]        wa_idx;
  logic [31:0]       area;
  logic              dims_ok, active, res_acc, wr_pend;

  sobel_win_addr #(.ADDR_W(ADDR_W)) u_win_addr (
    .clk   (clk),
    .rstn  (rstn),
    .init  (wa_init),
    .step  (wa_step),
    .w     (w_q),
    .h     (h_q),
    .addr  (wa_addr),
    .idx   (wa_idx),
    .last  (wa_last),
    .win_x (win_x),
    .win_y (win_y)
  );

  assign area    = 32'(W) * 32'(H);
  assign dims_ok = (W >= 16'd3) && (H >= 16'd3) && (area <= 32'(RES_BASE));
  assign active  = (state_q == FETCH) || (state_q == WAIT_RES);
  assign res_acc = bus.res_valid && active;
  // A held result not yet on the port claims the next request slot.
  assign wr_pend = active && hold_full_q && !hold_drain_q;

  // Next-state, result holding register and buffer-port arbitration.
  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    npix_d       = npix_q;
    nres_d       = nres_q;
    ld_cnt_d     = ld_cnt_q;
    res_cnt_d    = res_cnt_q;
    hold_full_d  = hold_full_q;
    hold_drain_d = hold_drain_q;
    hold_data_d  = hold_data_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    rd_d         = 1'b0;
    rd_idx_d     = rd_idx_q;
    ld_ready_d   = ld_ready_q;
    done_d       = 1'b0;
    err_d        = err_q;
    ovf_d        = ovf_q;
    wa_init      = 1'b0;
    wa_step      = 1'b0;
    win_valid_d  = rd_q;
    win_idx_d    = rd_idx_q;
    win_last_d   = rd_q && (rd_idx_q == 4'(WIN_PIX - 1));

    // The holding register empties in the cycle its write is on the port.
    if (hold_drain_q) begin
      hold_full_d  = 1'b0;
      hold_drain_d = 1'b0;
    end
    if (res_acc) begin
      if (!hold_full_q || hold_drain_q) begin
        hold_full_d = 1'b1;
        hold_data_d = bus.res_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (wr_pend) begin
      mem_addr_d   = RES_BASE + ADDR_W'(res_cnt_q);
      mem_we_d     = 1'b1;
      mem_wdata_d  = hold_data_q;
      hold_drain_d = 1'b1;
      res_cnt_d    = res_cnt_q + 32'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d       = W;
          h_d       = H;
          npix_d    = area;
          nres_d    = 32'(W - 16'd2) * 32'(H - 16'd2);
          ld_cnt_d  = '0;
          res_cnt_d = '0;
          ovf_d     = 1'b0;
          wa_init   = 1'b1;
          if (dims_ok) begin
            err_d      = 1'b0;
            ld_ready_d = 1'b1;
            state_d    = LOAD;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (bus.ld_valid && ld_ready_q) begin
          mem_addr_d  = ADDR_W'(ld_cnt_q);
          mem_we_d    = 1'b1;
          mem_wdata_d = bus.ld_data;
          ld_cnt_d    = ld_cnt_q + 32'd1;
          if (ld_cnt_q == npix_q - 32'd1) begin
            ld_ready_d = 1'b0;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        if (!wr_pend) begin
          mem_addr_d = wa_addr;
          rd_d       = 1'b1;
          rd_idx_d   = wa_idx;
          wa_step    = 1'b1;
          if (wa_last) state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if ((res_cnt_q == nres_q) && !hold_full_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      npix_q       <= '0;
      nres_q       <= '0;
      ld_cnt_q     <= '0;
      res_cnt_q    <= '0;
      hold_full_q  <= 1'b0;
      hold_drain_q <= 1'b0;
      hold_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      rd_q         <= 1'b0;
      rd_idx_q     <= '0;
      win_valid_q  <= 1'b0;
      win_idx_q    <= '0;
      win_last_q   <= 1'b0;
      ld_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      npix_q       <= npix_d;
      nres_q       <= nres_d;
      ld_cnt_q     <= ld_cnt_d;
      res_cnt_q    <= res_cnt_d;
      hold_full_q  <= hold_full_d;
      hold_drain_q <= hold_drain_d;
      hold_data_q  <= hold_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_q         <= rd_d;
      rd_idx_q     <= rd_idx_d;
      win_valid_q  <= win_valid_d;
      win_idx_q    <= win_idx_d;
      win_last_q   <= win_last_d;
      ld_ready_q   <= ld_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.ld_ready  = ld_ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.win_valid = win_valid_q;
  // Read data arrives the cycle after the request and is forwarded as-is.
  assign bus.win_pix   = win_valid_q ? bus.mem_rdata : 8'd0;
  assign bus.win_idx   = win_idx_q;
  assign bus.win_last  = win_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_sobel_frame_sched.sv
// Directed bench for sobel_frame_sched with window and result scoreboards.
module tb_sobel_frame_sched;

  localparam logic [19:0] RES_BASE = 20'h80000;

  typedef struct {
    logic [7:0] pix;
    logic [3:0] idx;
    logic       last;
    int         x;
    int         y;
  } win_t;

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
  } res_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] W, H;
  logic        busy, done, err, ovf;
  logic [15:0] win_x, win_y;

  sobel_frame_sched_if #(.ADDR_W(20)) bus ();

  sobel_frame_sched #(.ADDR_W(20), .RES_BASE(RES_BASE)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .W     (W),
    .H     (H),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .ovf   (ovf),
    .win_x (win_x),
    .win_y (win_y),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<20)-1];
  logic [7:0] frame [0:24];
  win_t       win_q [$];
  res_t       res_q [$];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         we_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Buffer model: registered read, one cycle latency.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Output monitor: pops the scoreboards as the DUT produces pixels and result writes.
  always @(negedge clk) begin
    if (bus.mem_we) we_cnt++;
    if (done) done_cnt++;
    if (bus.win_valid) begin
      if (win_q.size() == 0) begin
        check("win_unexpected", 32'(bus.win_valid), 32'd0);
      end else begin
        win_t e;
        e = win_q.pop_front();
        check("win_pix", 32'(bus.win_pix), 32'(e.pix));
        check("win_idx", 32'(bus.win_idx), 32'(e.idx));
        check("win_last", 32'(bus.win_last), 32'(e.last));
        if (e.idx == 4'd0) begin
          check("win_x", 32'(win_x), 32'(e.x));
          check("win_y", 32'(win_y), 32'(e.y));
        end
      end
    end
    if (bus.mem_we && (bus.mem_addr >= RES_BASE)) begin
      if (res_q.size() == 0) begin
        check("res_unexpected", 32'(bus.mem_we), 32'd0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("res_addr", 32'(bus.mem_addr), 32'(r.addr));
        check("res_data", 32'(bus.mem_wdata), 32'(r.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] w, input logic [15:0] h);
    start = 1'b1;
    W     = w;
    H     = h;
    tick();
    start = 1'b0;
  endtask

  task automatic push_windows(input int w, input int h);
    for (int y = 0; y <= h - 3; y++)
      for (int x = 0; x <= w - 3; x++)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            win_t e;
            e.pix  = frame[(y + r) * w + x + c];
            e.idx  = 4'(r * 3 + c);
            e.last = (r == 2) && (c == 2);
            e.x    = x;
            e.y    = y;
            win_q.push_back(e);
          end
  endtask

  task automatic load_frame(input int n);
    for (int i = 0; i < n; i++) begin
      int b;
      b = 0;
      bus.ld_valid = 1'b1;
      bus.ld_data  = frame[i];
      while (!bus.ld_ready && b < 100) begin
        tick();
        b++;
      end
      if (b >= 100) check("ld_ready_wait", 32'(bus.ld_ready), 32'd1);
      tick();
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic wait_win_drain(input int budget);
    int b;
    b = 0;
    while (win_q.size() != 0 && b < budget) begin
      tick();
      b++;
    end
    check("win_drain", 32'(win_q.size()), 32'd0);
  endtask

  task automatic wait_done(input int base, input int budget);
    int b;
    b = 0;
    while (done_cnt == base && b < budget) begin
      tick();
      b++;
    end
    check("done_seen", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic res_pulse(input logic [7:0] d);
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    tick();
    bus.res_valid = 1'b0;
  endtask

  initial begin
    int d0, w0;
    rstn          = 1'b0;
    start         = 1'b0;
    W             = '0;
    H             = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    repeat (3) tick();
    check("rst_flags", 32'({busy, done, err, ovf, bus.ld_ready, bus.mem_we, bus.win_valid, bus.win_last}), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_win_xy", {win_x, win_y}, 32'd0);
    rstn = 1'b1;
    tick();

    // 3x3 frame, pixels 1..9: one window, then parked in WAIT_RES until its result.
    for (int i = 0; i < 9; i++) frame[i] = 8'(i + 1);
    push_windows(3, 3);
    do_start(16'd3, 16'd3);
    check("load_ready", 32'(bus.ld_ready), 32'd1);
    load_frame(9);
    check("ready_low_after_load", 32'(bus.ld_ready), 32'd0);
    wait_win_drain(50);
    d0 = done_cnt;
    repeat (5) tick();
    check("wait_res_busy", 32'(busy), 32'd1);
    check("wait_res_no_done", 32'(done_cnt - d0), 32'd0);
    res_q.push_back('{addr: RES_BASE, data: 8'h3C});
    res_pulse(8'h3C);
    wait_done(d0, 20);
    tick();
    check("f1_idle", 32'({busy, err, ovf}), 32'd0);

    // 4x4 ramp, one result after each window; stray start/res during LOAD ignored.
    for (int i = 0; i < 16; i++) frame[i] = 8'(i);
    push_windows(4, 4);
    d0 = done_cnt;
    do_start(16'd4, 16'd4);
    do_start(16'd2, 16'd2);
    res_pulse(8'hEE);
    check("start_in_load_ignored", 32'({err, bus.ld_ready}), 32'd1);
    load_frame(16);
    for (int k = 0; k < 4; k++) begin
      int b;
      b = 0;
      @(negedge clk);
      while (!(bus.win_valid && bus.win_last) && b < 200) begin
        @(negedge clk);
        b++;
      end
      if (b >= 200) check("win_last_wait", 32'(bus.win_last), 32'd1);
      res_q.push_back('{addr: RES_BASE + 20'(k), data: 8'hA0 + 8'(k)});
      bus.res_valid = 1'b1;
      bus.res_data  = 8'hA0 + 8'(k);
      @(negedge clk);
      bus.res_valid = 1'b0;
      @(negedge clk);
      check("res_write_slot", 32'(bus.mem_we), 32'd1);
      @(negedge clk);
      check("res_stall_gap", 32'(bus.win_valid), 32'd0);
    end
    wait_done(d0, 50);
    repeat (4) tick();
    check("f2_done_once", 32'(done_cnt - d0), 32'd1);
    check("f2_res_drained", 32'(res_q.size()), 32'd0);
    check("f2_win_drained", 32'(win_q.size()), 32'd0);

    // Two back-to-back results: second one overflows and is dropped.
    for (int i = 0; i < 9; i++) frame[i] = 8'(90 - i);
    push_windows(3, 3);
    d0 = done_cnt;
    do_start(16'd3, 16'd3);
    load_frame(9);
    wait_win_drain(50);
    res_q.push_back('{addr: RES_BASE, data: 8'h55});
    bus.res_valid = 1'b1;
    bus.res_data  = 8'h55;
    tick();
    bus.res_data  = 8'h66;
    tick();
    bus.res_valid = 1'b0;
    wait_done(d0, 20);
    repeat (3) tick();
    check("ovf_sticky", 32'(ovf), 32'd1);
    check("ovf_one_write", 32'(res_q.size()), 32'd0);

    // Bad dimensions: err, done pulse next cycle, no buffer writes.
    w0 = we_cnt;
    do_start(16'd2, 16'd5);
    check("err_set", 32'({err, done, ovf}), 32'b110);
    tick();
    check("err_done_pulse_end", 32'({done, busy}), 32'd0);
    check("err_sticky", 32'(err), 32'd1);
    check("err_no_write", 32'(we_cnt - w0), 32'd0);

    // 5x5 frame reset mid-FETCH, then reloaded with different pixels.
    for (int i = 0; i < 25; i++) frame[i] = 8'(3 * i + 7);
    push_windows(5, 5);
    do_start(16'd5, 16'd5);
    check("err_cleared", 32'(err), 32'd0);
    load_frame(25);
    begin
      int b;
      b = 0;
      while (win_q.size() > 81 - 12 && b < 100) begin
        tick();
        b++;
      end
      check("mid_fetch_reached", 32'(win_q.size() <= 81 - 12), 32'd1);
    end
    rstn = 1'b0;
    tick();
    check("rst_mid_flags", 32'({busy, done, err, ovf, bus.ld_ready, bus.mem_we, bus.win_valid, bus.win_last}), 32'd0);
    check("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mid_data", 32'({bus.mem_wdata, bus.win_pix, bus.win_idx}), 32'd0);
    check("rst_mid_xy", {win_x, win_y}, 32'd0);
    rstn = 1'b1;
    win_q.delete();
    tick();
    check("rst_no_late_pix", 32'(bus.win_valid), 32'd0);
    for (int i = 0; i < 25; i++) frame[i] = 8'(200 - 5 * i);
    push_windows(5, 5);
    d0 = done_cnt;
    do_start(16'd5, 16'd5);
    load_frame(25);
    wait_win_drain(300);
    check("reload_wait_res", 32'(busy), 32'd1);
    check("reload_no_done", 32'(done_cnt - d0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_sched.md
SOBEL_FRAME_SCHED -- requirements
Module: sobel_frame_sched

Interface
REQ-001 Parameter ADDR_W, default 20: frame-buffer address width.
REQ-002 Parameter RES_BASE, default 20'h80000: first result address in the shared buffer.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  begin one frame; accepted only in IDLE.
REQ-006 W, H  in  16 each  frame width and height, sampled on an accepted start.
REQ-007 ld_valid / ld_data / ld_ready  in 1 / in 8 / out 1  loader pixel stream; transfer when valid and ready are both high.
REQ-008 mem_addr / mem_we / mem_wdata  out ADDR_W / out 1 / out 8  single-port buffer request, one per cycle.
REQ-009 mem_rdata  in  8  read data, valid exactly 1 cycle after a read request.
REQ-010 win_valid / win_pix / win_idx / win_last  out 1 / 8 / 4 / 1  window pixel stream to the Sobel core; idx 0..8 row-major.
REQ-011 res_valid / res_data  in 1 / in 8  Sobel result strobe and value.
REQ-012 busy / done / err / ovf  out 1 each  not IDLE / 1-cycle completion pulse / bad dimensions / result overflow (sticky until start).
REQ-013 win_x, win_y  out 16 each  top-left coordinate of the window being fetched.

Function
REQ-014 FSM states: IDLE, LOAD, FETCH, WAIT_RES, DONE.
REQ-015 IDLE: on start, W>=3, H>=3 and W*H<=RES_BASE -> LOAD; otherwise err=1 and go to DONE.
REQ-016 LOAD: ld_ready=1; each transfer writes ld_data at addresses 0,1,2... in order; after the W*H-th transfer -> FETCH with ld_ready low from the next cycle.
REQ-017 FETCH: per window, 9 reads at (win_y+r)*W+(win_x+c), r,c in 0..2, row-major, one per cycle unless stalled.
REQ-018 Read data returns the next cycle as win_valid=1 with win_pix=mem_rdata, win_idx = the request's index, and win_last=1 on idx 8.
REQ-019 Window order: win_x 0..W-3, then win_x wraps to 0 and win_y increments; last window (W-3,H-3) -> WAIT_RES after its 9th read.
REQ-020 Row base addresses use an adder (base += W); no multiplier in the address path.
REQ-021 Result write: a res_valid pulse loads a 1-entry holding register.
REQ-022 Holding-register write goes to RES_BASE+res_cnt, and res_cnt increments.
REQ-023 A pending write takes the port over a FETCH read; the read stalls one cycle and that cycle emits no win_valid.
REQ-024 res_valid while holding is full and not draining that cycle: ovf=1, and the new result is dropped.
REQ-025 res_valid in the same cycle the holding register drains is accepted without overflow.
REQ-026 WAIT_RES -> DONE when res_cnt == (W-2)*(H-2) and holding is empty.
REQ-027 DONE: done=1 for one cycle -> IDLE; err/ovf keep their value until the next accepted start.
REQ-028 start outside IDLE is ignored.
REQ-029 res_valid in IDLE or LOAD is ignored.
REQ-030 mem_we=0 and mem_addr holds its value on cycles with no request.

Reset
REQ-031 rstn=0 at a clock edge -> state IDLE, from any state including mid-LOAD or mid-FETCH.
REQ-032 Reset values: all outputs 0, counters and res_cnt 0, holding register empty; no pending read completes.
REQ-033 Buffer contents are not cleared by reset.

Structure
REQ-034 Package sobel_pkg holds the FSM state enum, the default ADDR_W and RES_BASE, and a WIN_PIX=9 constant.
REQ-035 Window address generation (row bases, r/c/x/y counters, last-window detect) is one sub-module, sobel_win_addr; arbitration and FSM stay in the top.

Verification
REQ-036 3x3 frame, pixels 1..9, no res -> 9 win pixels, idx 0..8, values 1..9; win_last on 9; waits in WAIT_RES.
REQ-037 4x4 frame, ramp 0..15, res_valid after each win_last -> 4 windows at (0,0),(1,0),(0,1),(1,1); window (1,1) pixels 5,6,7,9,10,11,13,14,15; results at RES_BASE..+3; done pulse once.
REQ-038 res_valid mid-window -> that cycle is a write (mem_we=1), fetch stalls one cycle, and the 9-pixel order is preserved.
REQ-039 res_valid on two consecutive cycles while a write is pending -> ovf=1, res_cnt advances by 1 only.
REQ-040 start with W=2,H=5 -> err=1, done pulse 1 cycle later, no mem_we.
REQ-041 rstn low during FETCH of a 5x5 frame -> IDLE, all outputs 0 next cycle; new start then reloads correctly.
